axil_uart_regs: RTL and testbench

AXI4-Lite slave register front-end for the UART core. It is the host-side responder that drains the RX FIFO and fills the TX FIFO. It maps four 32-bit registers onto the UART FIFO and enable interface: RX data, TX data, status and control. It sits between the system AXI-Lite interconnect and the UART top-level pins RX_data, Empty, rd_uart_en, TX_data, wr_uart_en, Full, Enable_rx and Enable_tx.

---
 rtl/axil_uart_regs.sv | 221 ++++++++++++++++++++++
 tb/tb_axil_uart_regs.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_uart_regs.sv
// ---------------------------------------------------------------------------
// axil_uart_regs
// AXI4-Lite slave register front-end for the UART core. Maps four 32-bit
// registers onto the UART FIFO / enable interface:
//   0x0 RXDATA  (RO)  {23'b0, valid, byte}, a successful read pops the RX FIFO
//   0x4 TXDATA  (WO)  byte write pushes into the TX FIFO, reads return 0
//   0x8 STATUS  (RO)  {rx_unf, tx_ovf, Full, Empty}, a read clears the stickies
//   0xC CTRL    (RW)  {Enable_tx, Enable_rx}
// Ports:
//   Clk, Reset        single clock domain, asynchronous active-high reset
//   S_AXI_*           AXI4-Lite slave (AW/W accepted together, B, AR, R)
//   RX_data, Empty    RX FIFO head (first-word-fall-through) and empty flag
//   rd_uart_en        one-cycle RX FIFO pop, asserted in the AR accept cycle
//   TX_data           byte pushed into the TX FIFO
//   wr_uart_en        one-cycle TX FIFO push, registered from the write accept
//   Full              TX FIFO full
//   Enable_rx/_tx     UART receiver / transmitter enables
// ---------------------------------------------------------------------------
module axil_uart_regs #(
    parameter int C_ADDR_WIDTH = 4,
    parameter int C_DATA_WIDTH = 32
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [C_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                      S_AXI_AWVALID,
    output logic                      S_AXI_AWREADY,
    input  logic [C_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [3:0]                S_AXI_WSTRB,
    input  logic                      S_AXI_WVALID,
    output logic                      S_AXI_WREADY,
    output logic [1:0]                S_AXI_BRESP,
    output logic                      S_AXI_BVALID,
    input  logic                      S_AXI_BREADY,
    input  logic [C_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                      S_AXI_ARVALID,
    output logic                      S_AXI_ARREADY,
    output logic [C_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                S_AXI_RRESP,
    output logic                      S_AXI_RVALID,
    input  logic                      S_AXI_RREADY,
    input  logic [7:0]                RX_data,
    input  logic                      Empty,
    output logic                      rd_uart_en,
    output logic [7:0]                TX_data,
    output logic                      wr_uart_en,
    input  logic                      Full,
    output logic                      Enable_rx,
    output logic                      Enable_tx
);

    localparam logic [1:0] ADDR_RXDATA = 2'd0;
    localparam logic [1:0] ADDR_TXDATA = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic W_IDLE = 1'b0;
    localparam logic W_RESP = 1'b1;
    localparam logic R_IDLE = 1'b0;
    localparam logic R_DATA = 1'b1;

    logic                    w_state_q, w_state_d;
    logic [1:0]              bresp_q, bresp_d;
    logic [7:0]              tx_data_q, tx_data_d;
    logic                    wr_en_q, wr_en_d;
    logic                    en_rx_q, en_rx_d;
    logic                    en_tx_q, en_tx_d;
    logic                    tx_ovf_q, tx_ovf_d;
    logic                    rx_unf_q, rx_unf_d;
    logic                    r_state_q, r_state_d;
    logic [C_DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic       wr_accept;
    logic       rd_accept;
    logic [1:0] w_addr;
    logic [1:0] r_addr;
    logic       tx_ovf_set;
    logic       rx_unf_set;
    logic       sticky_clr;

    // Only addr[3:2], WDATA[7:0] and WSTRB[0] carry meaning; the rest is
    // folded here so the unused bits are visibly intentional.
    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWADDR, S_AXI_ARADDR, S_AXI_WDATA, S_AXI_WSTRB};

    assign w_addr = S_AXI_AWADDR[3:2];
    assign r_addr = S_AXI_ARADDR[3:2];

    // Address and data must arrive together; readies are gated by Reset so
    // nothing is accepted (and no pop is issued) while reset is held.
    assign wr_accept = !Reset && (w_state_q == W_IDLE) && S_AXI_AWVALID && S_AXI_WVALID;
    assign rd_accept = !Reset && (r_state_q == R_IDLE) && S_AXI_ARVALID;

    assign S_AXI_AWREADY = wr_accept;
    assign S_AXI_WREADY  = wr_accept;
    assign S_AXI_BVALID  = (w_state_q == W_RESP);
    assign S_AXI_BRESP   = bresp_q;

    assign S_AXI_ARREADY = !Reset && (r_state_q == R_IDLE);
    assign S_AXI_RVALID  = (r_state_q == R_DATA);
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = RESP_OKAY;

    // The RX FIFO is first-word-fall-through, so the pop is issued in the same
    // cycle the head byte is captured into RDATA.
    assign rd_uart_en = rd_accept && (r_addr == ADDR_RXDATA) && !Empty;
    assign wr_uart_en = wr_en_q;
    assign TX_data    = tx_data_q;
    assign Enable_rx  = en_rx_q;
    assign Enable_tx  = en_tx_q;

    // Write channel: accept, apply the register effect, hold the response.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        w_state_d  = w_state_q;
        bresp_d    = bresp_q;
        tx_data_d  = tx_data_q;
        wr_en_d    = 1'b0;
        en_rx_d    = en_rx_q;
        en_tx_d    = en_tx_q;
        tx_ovf_set = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (wr_accept) begin
                    w_state_d = W_RESP;
                    bresp_d   = RESP_OKAY;
                    case (w_addr)
                        ADDR_TXDATA: begin
                            if (S_AXI_WSTRB[0]) begin
                                if (!Full) begin
                                    wr_en_d   = 1'b1;
                                    tx_data_d = S_AXI_WDATA[7:0];
                                end else begin
                                    tx_ovf_set = 1'b1;
                                end
                            end
                        end
                        ADDR_CTRL: begin
                            if (S_AXI_WSTRB[0]) begin
                                en_rx_d = S_AXI_WDATA[0];
                                en_tx_d = S_AXI_WDATA[1];
                            end
                        end
                        default: bresp_d = RESP_SLVERR;
                    endcase
                end
            end
            default: begin
                if (S_AXI_BREADY) w_state_d = W_IDLE;
            end
        endcase
    end

    // Read channel: capture the addressed value at accept, hold until taken.
    always_comb begin
        r_state_d  = r_state_q;
        rdata_d    = rdata_q;
        rx_unf_set = 1'b0;
        sticky_clr = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (rd_accept) begin
                    r_state_d = R_DATA;
                    rdata_d   = '0;
                    case (r_addr)
                        ADDR_RXDATA: begin
                            if (!Empty) rdata_d[8:0] = {1'b1, RX_data};
                            else        rx_unf_set   = 1'b1;
                        end
                        ADDR_STATUS: begin
                            rdata_d[3:0] = {rx_unf_q, tx_ovf_q, Full, Empty};
                            sticky_clr   = 1'b1;
                        end
                        ADDR_CTRL:   rdata_d[1:0] = {en_tx_q, en_rx_q};
                        default:     rdata_d      = '0;
                    endcase
                end
            end
            default: begin
                if (S_AXI_RREADY) r_state_d = R_IDLE;
            end
        endcase
    end

    // A set event in the same cycle as a STATUS read keeps the flag set.
    assign tx_ovf_d = tx_ovf_set || (tx_ovf_q && !sticky_clr);
    assign rx_unf_d = rx_unf_set || (rx_unf_q && !sticky_clr);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            w_state_q <= W_IDLE;
            bresp_q   <= RESP_OKAY;
            tx_data_q <= 8'h00;
            wr_en_q   <= 1'b0;
            en_rx_q   <= 1'b0;
            en_tx_q   <= 1'b0;
            tx_ovf_q  <= 1'b0;
            rx_unf_q  <= 1'b0;
            r_state_q <= R_IDLE;
            rdata_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge value of the others, independent of statement order.
            w_state_q <= w_state_d;
            bresp_q   <= bresp_d;
            tx_data_q <= tx_data_d;
            wr_en_q   <= wr_en_d;
            en_rx_q   <= en_rx_d;
            en_tx_q   <= en_tx_d;
            tx_ovf_q  <= tx_ovf_d;
            rx_unf_q  <= rx_unf_d;
            r_state_q <= r_state_d;
            rdata_q   <= rdata_d;
        end
    end

endmodule

// File: tb/tb_axil_uart_regs.sv
// ---------------------------------------------------------------------------
// tb_axil_uart_regs
// Directed bench for axil_uart_regs. Inputs change 1 ns after the rising
// edge; outputs are compared on the falling edge against a transaction-level
// model of the register file (enables, sticky flags, expected strobes and
// pending responses), plus literal expectations for individual reads.
// ---------------------------------------------------------------------------
module tb_axil_uart_regs;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [3:0]  S_AXI_AWADDR;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [3:0]  S_AXI_ARADDR;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;
    logic [7:0]  RX_data;
    logic        Empty;
    logic        rd_uart_en;
    logic [7:0]  TX_data;
    logic        wr_uart_en;
    logic        Full;
    logic        Enable_rx;
    logic        Enable_tx;

    axil_uart_regs #(.C_ADDR_WIDTH(4), .C_DATA_WIDTH(32)) dut (
        .Clk(Clk), .Reset(Reset),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .RX_data(RX_data), .Empty(Empty), .rd_uart_en(rd_uart_en),
        .TX_data(TX_data), .wr_uart_en(wr_uart_en), .Full(Full),
        .Enable_rx(Enable_rx), .Enable_tx(Enable_tx)
    );

    always #5 Clk = ~Clk;

    localparam logic [3:0] A_RX = 4'h0, A_TX = 4'h4, A_ST = 4'h8, A_CT = 4'hC;

    int n_checks = 0;
    int n_errors = 0;

    // Model of what the block must present.
    logic        m_en_rx = 1'b0, m_en_tx = 1'b0;
    logic        m_tx_ovf = 1'b0, m_rx_unf = 1'b0;
    logic        m_push_now = 1'b0, m_pop_now = 1'b0;
    logic [7:0]  m_push_byte = 8'h00;
    logic        m_bvalid = 1'b0, m_rvalid = 1'b0;
    logic [1:0]  m_bresp = 2'b00;
    logic [31:0] m_rdata = 32'h0;

    int n_push = 0, n_pop = 0;
    logic [7:0] last_tx = 8'h00;

    logic [1:0]  bresp_a, bresp_b;
    logic [31:0] rd_a, rd_b;
    int push0, pop0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge Clk) begin
        check("enable_rx", 32'(Enable_rx), 32'(m_en_rx));
        check("enable_tx", 32'(Enable_tx), 32'(m_en_tx));
        check("wr_uart_en", 32'(wr_uart_en), 32'(m_push_now));
        if (m_push_now) check("tx_data", 32'(TX_data), 32'(m_push_byte));
        check("rd_uart_en", 32'(rd_uart_en), 32'(m_pop_now));
        check("bvalid", 32'(S_AXI_BVALID), 32'(m_bvalid));
        if (m_bvalid) check("bresp", 32'(S_AXI_BRESP), 32'(m_bresp));
        check("rvalid", 32'(S_AXI_RVALID), 32'(m_rvalid));
        if (m_rvalid) begin
            check("rdata", S_AXI_RDATA, m_rdata);
            check("rresp", 32'(S_AXI_RRESP), 32'h0);
        end
    end

    always @(negedge Clk) begin
        if (wr_uart_en) begin
            n_push++;
            last_tx = TX_data;
        end
        if (rd_uart_en) n_pop++;
    end

    // lead: cycles AWVALID is shown alone; hold: cycles BREADY is withheld
    // (AW/W stay asserted meanwhile and must not be accepted).
    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int lead, input int hold, output logic [1:0] bresp_got);
        logic [1:0] resp;
        logic       set_ovf;
        @(posedge Clk); #1;
        S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = (lead == 0); S_AXI_BREADY = 1'b0;
        for (int i = 0; i < lead; i++) begin
            @(negedge Clk);
            check("aw_alone_not_accepted", 32'({S_AXI_AWREADY, S_AXI_WREADY}), 32'h0);
            @(posedge Clk); #1;
        end
        S_AXI_WVALID = 1'b1;
        @(negedge Clk);
        check("aw_w_accept", 32'({S_AXI_AWREADY, S_AXI_WREADY}), 32'h3);
        @(posedge Clk); #1;
        resp = 2'b00; set_ovf = 1'b0;
        case (addr[3:2])
            2'd1: if (strb[0]) begin
                if (!Full) begin m_push_now = 1'b1; m_push_byte = data[7:0]; end
                else set_ovf = 1'b1;
            end
            2'd3: if (strb[0]) begin m_en_rx = data[0]; m_en_tx = data[1]; end
            default: resp = 2'b10;
        endcase
        m_bvalid = 1'b1; m_bresp = resp;
        S_AXI_AWVALID = (hold > 0); S_AXI_WVALID = (hold > 0);
        // Applied after any concurrent STATUS clear, since a set must win.
        if (set_ovf) begin #1; m_tx_ovf = 1'b1; end
        for (int i = 0; i < hold; i++) begin
            @(negedge Clk);
            check("stall_awready", 32'({S_AXI_AWREADY, S_AXI_WREADY}), 32'h0);
            @(posedge Clk); #1;
            m_push_now = 1'b0;
        end
        S_AXI_BREADY = 1'b1;
        @(negedge Clk);
        bresp_got = S_AXI_BRESP;
        @(posedge Clk); #1;
        m_push_now = 1'b0; m_bvalid = 1'b0;
        S_AXI_BREADY = 1'b0; S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    endtask

    // hold: cycles RREADY is withheld (ARVALID stays asserted meanwhile).
    task automatic axi_read(input logic [3:0] addr, input int hold, output logic [31:0] got);
        logic [31:0] exp;
        logic        clr, set_unf;
        @(posedge Clk); #1;
        S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
        exp = 32'h0; clr = 1'b0; set_unf = 1'b0;
        case (addr[3:2])
            2'd0: if (!Empty) begin exp = {23'b0, 1'b1, RX_data}; m_pop_now = 1'b1; end
                  else set_unf = 1'b1;
            2'd2: begin exp = 32'({m_rx_unf, m_tx_ovf, Full, Empty}); clr = 1'b1; end
            2'd3: exp = 32'({m_en_tx, m_en_rx});
            default: exp = 32'h0;
        endcase
        @(negedge Clk);
        check("ar_accept", 32'(S_AXI_ARREADY), 32'h1);
        @(posedge Clk); #1;
        m_pop_now = 1'b0; m_rvalid = 1'b1; m_rdata = exp;
        if (clr) begin m_tx_ovf = 1'b0; m_rx_unf = 1'b0; end
        if (set_unf) m_rx_unf = 1'b1;
        S_AXI_ARVALID = (hold > 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge Clk);
            check("stall_arready", 32'(S_AXI_ARREADY), 32'h0);
            @(posedge Clk); #1;
        end
        S_AXI_RREADY = 1'b1;
        @(negedge Clk);
        got = S_AXI_RDATA;
        @(posedge Clk); #1;
        m_rvalid = 1'b0; S_AXI_RREADY = 1'b0; S_AXI_ARVALID = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        Reset = 1'b1;
        S_AXI_AWADDR = 4'h0; S_AXI_AWVALID = 1'b0; S_AXI_WDATA = 32'h0; S_AXI_WSTRB = 4'h0;
        S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0; S_AXI_ARADDR = 4'h0; S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY = 1'b0; RX_data = 8'h00; Empty = 1'b1; Full = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check("rst_awready", 32'(S_AXI_AWREADY), 32'h0);
        check("rst_arready", 32'(S_AXI_ARREADY), 32'h0);
        check("rst_rdata", S_AXI_RDATA, 32'h0);
        check("rst_tx_data", 32'(TX_data), 32'h0);
        check("rst_bresp", 32'(S_AXI_BRESP), 32'h0);
        Reset = 1'b0;

        // CTRL write / read back.
        axi_write(A_CT, 32'h3, 4'hF, 0, 0, bresp_a);
        check("ctrl_bresp", 32'(bresp_a), 32'h0);
        check("ctrl_enables", 32'({Enable_tx, Enable_rx}), 32'h3);
        axi_read(A_CT, 0, rd_a);
        check("ctrl_read", rd_a, 32'h3);

        // TX push, then overflow with Full=1.
        Empty = 1'b0; RX_data = 8'h00;
        push0 = n_push;
        axi_write(A_TX, 32'hA5, 4'hF, 0, 0, bresp_a);
        check("tx_push_count", 32'(n_push - push0), 32'h1);
        check("tx_push_byte", 32'(last_tx), 32'hA5);
        check("tx_bresp", 32'(bresp_a), 32'h0);
        Full = 1'b1;
        push0 = n_push;
        axi_write(A_TX, 32'h11, 4'h1, 0, 0, bresp_a);
        check("tx_full_no_push", 32'(n_push - push0), 32'h0);
        check("tx_full_bresp", 32'(bresp_a), 32'h0);
        axi_read(A_ST, 0, rd_a);
        check("status_ovf", rd_a, 32'h6);
        axi_read(A_ST, 0, rd_a);
        check("status_ovf_cleared", rd_a, 32'h2);
        Full = 1'b0;

        // RX pop and underflow.
        RX_data = 8'h3C; pop0 = n_pop;
        axi_read(A_RX, 0, rd_a);
        check("rx_read", rd_a, 32'h13C);
        check("rx_pop_count", 32'(n_pop - pop0), 32'h1);
        Empty = 1'b1; pop0 = n_pop;
        axi_read(A_RX, 0, rd_a);
        check("rx_empty_read", rd_a, 32'h0);
        check("rx_empty_no_pop", 32'(n_pop - pop0), 32'h0);
        axi_read(A_ST, 0, rd_a);
        check("status_unf", rd_a, 32'h9);
        axi_read(A_ST, 0, rd_a);
        check("status_unf_cleared", rd_a, 32'h1);

        // Back-pressure on R and B.
        Empty = 1'b0; RX_data = 8'h77; pop0 = n_pop;
        axi_read(A_RX, 5, rd_a);
        check("rx_stall_read", rd_a, 32'h177);
        check("rx_stall_one_pop", 32'(n_pop - pop0), 32'h1);
        axi_write(A_CT, 32'h1, 4'hF, 0, 5, bresp_a);
        check("ctrl_stall_bresp", 32'(bresp_a), 32'h0);

        // Read-only targets answer SLVERR and change nothing.
        axi_write(A_ST, 32'hFF, 4'hF, 0, 0, bresp_a);
        check("status_write_slverr", 32'(bresp_a), 32'h2);
        axi_write(A_RX, 32'hFF, 4'hF, 0, 0, bresp_a);
        check("rxdata_write_slverr", 32'(bresp_a), 32'h2);
        axi_read(A_CT, 0, rd_a);
        check("ctrl_after_slverr", rd_a, 32'h1);

        // Lone AWVALID, strobe-less writes, TXDATA read.
        push0 = n_push;
        axi_write(A_TX, 32'h42, 4'h1, 4, 0, bresp_a);
        check("aw_lead_push_byte", 32'(last_tx), 32'h42);
        axi_write(A_TX, 32'h55, 4'hE, 0, 0, bresp_a);
        check("tx_nostrb_pushes", 32'(n_push - push0), 32'h1);
        axi_write(A_CT, 32'h2, 4'hE, 0, 0, bresp_a);
        check("ctrl_nostrb_bresp", 32'(bresp_a), 32'h0);
        axi_read(A_CT, 0, rd_a);
        check("ctrl_nostrb_read", rd_a, 32'h1);
        axi_read(A_TX, 0, rd_a);
        check("txdata_read_zero", rd_a, 32'h0);

        // Concurrent write and read; then set-vs-clear in one cycle.
        push0 = n_push;
        fork
            axi_write(A_TX, 32'h99, 4'h1, 0, 0, bresp_b);
            axi_read(A_ST, 0, rd_b);
        join
        check("conc_status", rd_b, 32'h0);
        check("conc_push", 32'(n_push - push0), 32'h1);
        Full = 1'b1;
        fork
            axi_write(A_TX, 32'h12, 4'h1, 0, 0, bresp_b);
            axi_read(A_ST, 0, rd_b);
        join
        check("setwin_status", rd_b, 32'h2);
        axi_read(A_ST, 0, rd_a);
        check("setwin_sticky_kept", rd_a, 32'h6);
        Full = 1'b0;

        // Reset in the middle of B and R responses (tx_ovf set beforehand).
        Full = 1'b1;
        axi_write(A_TX, 32'h13, 4'h1, 0, 0, bresp_a);
        Full = 1'b0; Empty = 1'b0; RX_data = 8'h5E;
        axi_write(A_CT, 32'h3, 4'hF, 0, 0, bresp_a);
        @(posedge Clk); #1;
        S_AXI_AWADDR = A_TX; S_AXI_WDATA = 32'h5A; S_AXI_WSTRB = 4'h1;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
        S_AXI_ARADDR = A_RX; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
        m_pop_now = 1'b1;
        @(posedge Clk); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        m_pop_now = 1'b0; m_push_now = 1'b1; m_push_byte = 8'h5A;
        m_bvalid = 1'b1; m_bresp = 2'b00; m_rvalid = 1'b1; m_rdata = 32'h15E;
        @(negedge Clk); #1;
        Reset = 1'b1;
        m_push_now = 1'b0; m_bvalid = 1'b0; m_rvalid = 1'b0;
        m_en_rx = 1'b0; m_en_tx = 1'b0; m_tx_ovf = 1'b0; m_rx_unf = 1'b0;
        #1;
        check("rst_mid_bvalid", 32'(S_AXI_BVALID), 32'h0);
        check("rst_mid_rvalid", 32'(S_AXI_RVALID), 32'h0);
        check("rst_mid_wr_uart_en", 32'(wr_uart_en), 32'h0);
        check("rst_mid_enables", 32'({Enable_tx, Enable_rx}), 32'h0);
        check("rst_mid_rdata", S_AXI_RDATA, 32'h0);
        check("rst_mid_tx_data", 32'(TX_data), 32'h0);
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
        push0 = n_push; pop0 = n_pop;
        #1;
        check("rst_mid_arready", 32'(S_AXI_ARREADY), 32'h0);
        check("rst_mid_awready", 32'({S_AXI_AWREADY, S_AXI_WREADY}), 32'h0);
        check("rst_mid_rd_uart_en", 32'(rd_uart_en), 32'h0);
        repeat (3) @(posedge Clk);
        #1;
        check("rst_held_no_strobes", 32'((n_push - push0) + (n_pop - pop0)), 32'h0);
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        Empty = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        axi_read(A_ST, 0, rd_a);
        check("post_rst_status", rd_a, 32'h1);
        axi_read(A_CT, 0, rd_a);
        check("post_rst_ctrl", rd_a, 32'h0);

        repeat (2) @(posedge Clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
